// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: instruction field positions, halt opcode default
// and the load-use hazard test.
package decode_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] HALT_OP_DEF = 6'h3F;

  // A load in EX whose destination feeds any operand of the instruction in ID
  // cannot be forwarded in time, so ID must hold the instruction for a cycle.
  function automatic logic load_use_hazard(input logic       vld,
                                           input logic       ld_vld,
                                           input logic [4:0] ld_rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2,
                                           input logic [4:0] rd);
    return vld && ld_vld && (ld_rd != 5'd0) &&
           ((ld_rd == rs1) || (ld_rd == rs2) || (ld_rd == rd));
  endfunction

endpackage

// File: rtl/decode_stage_p_reg_bank_bypass.sv
// NREG x XLEN register bank: one write port, three combinational read ports,
// R0 hardwired to zero, optional same-cycle writeback forwarding.
module reg_bank_bypass #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] d
);

  logic [XLEN-1:0] regs [NREG];

  // Matching only indices 1..NREG-1 drops writes to R0 and to out-of-range indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      for (int i = 1; i < NREG; i++)
        if (wb_rd == 5'(i)) regs[i] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    logic            hit;
    v   = '0;
    hit = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (idx == 5'(i)) begin
        v   = regs[i];
        hit = 1'b1;
      end
    if ((BYPASS_EN != 0) && hit && wb_en && (wb_rd == idx)) v = wb_data;
    return v;
  endfunction

  always_comb begin
    a = read_port(rs1);
    b = read_port(rs2);
    d = read_port(rd);
  end

endmodule

// File: rtl/decode_stage_p.sv
// ID stage: operand fetch through the bypassing register bank, load-use stall,
// flush, sticky halt and a registered ID/EX stage with valid/ready handshake.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         NREG      = 32,
  parameter int         SHIFT_EN  = 1,
  parameter int         BYPASS_EN = 1,
  parameter logic [5:0] HALT_OP   = HALT_OP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     npc_in,
  input  logic [31:0]     ir_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ld_vld,
  input  logic [4:0]      ex_ld_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [XLEN-1:0] d_o,
  output logic [XLEN-1:0] imm_o,
  output logic [31:0]     npc_o,
  output logic [31:0]     ir_o,
  output logic            hlt
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] imm;
    logic [31:0]     npc;
    logic [31:0]     ir;
  } id_ex_t;

  logic [5:0]        op;
  logic [4:0]        rd, rs1, rs2, sh;
  logic [XLEN-1:0]   a_rd, b_rd, d_rd;
  logic signed [15:0] imm16;
  id_ex_t            id_ex_p0;
  id_ex_t            id_ex_p1;
  logic              vld_p1;
  logic              hlt_p1;
  logic              hazard, advance, accept;

  assign op    = ir_in[OP_MSB:OP_LSB];
  assign rd    = ir_in[RD_MSB:RD_LSB];
  assign rs1   = ir_in[RS1_MSB:RS1_LSB];
  assign rs2   = ir_in[RS2_MSB:RS2_LSB];
  assign sh    = ir_in[SH_MSB:SH_LSB];
  assign imm16 = signed'(ir_in[IMM_MSB:IMM_LSB]);

  reg_bank_bypass #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .BYPASS_EN (BYPASS_EN)
  ) u_reg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .a       (a_rd),
    .b       (b_rd),
    .d       (d_rd)
  );

  // ---- p0: decode / operand formation ----
  always_comb begin
    id_ex_p0     = '0;
    id_ex_p0.a   = a_rd;
    id_ex_p0.b   = (SHIFT_EN != 0) ? (b_rd << sh) : b_rd;
    id_ex_p0.d   = d_rd;
    id_ex_p0.imm = {{(XLEN-16){imm16[15]}}, imm16};
    id_ex_p0.npc = npc_in;
    id_ex_p0.ir  = ir_in;
  end

  assign hazard   = load_use_hazard(in_valid, ex_ld_vld, ex_ld_rd, rs1, rs2, rd);
  assign advance  = !vld_p1 || out_ready;
  assign in_ready = advance && !hazard && !hlt_p1 && !flush;
  assign accept   = in_valid && in_ready;

  // ---- p1: ID/EX register ----
  // Flush also drops a pending halt, since the halt instruction itself was speculative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hlt_p1   <= 1'b0;
      id_ex_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      hlt_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      id_ex_p1 <= id_ex_p0;
      if (op == HALT_OP) hlt_p1 <= 1'b1;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign hlt       = hlt_p1;
  assign a_o       = id_ex_p1.a;
  assign b_o       = id_ex_p1.b;
  assign d_o       = id_ex_p1.d;
  assign imm_o     = id_ex_p1.imm;
  assign npc_o     = id_ex_p1.npc;
  assign ir_o      = id_ex_p1.ir;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p (XLEN=32): expected ID/EX payloads are queued on accept
// and compared when EX takes them; handshake, stall, flush, halt and reset checked each cycle.
module tb_decode_stage_p;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     npc_in, ir_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_ld_vld;
  logic [4:0]      ex_ld_rd;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] a_o, b_o, d_o, imm_o;
  logic [31:0]     npc_o, ir_o;
  logic            hlt;

  decode_stage_p #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .npc_in(npc_in), .ir_in(ir_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ld_vld(ex_ld_vld), .ex_ld_rd(ex_ld_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_o(a_o), .b_o(b_o), .d_o(d_o), .imm_o(imm_o), .npc_o(npc_o), .ir_o(ir_o), .hlt(hlt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, d, imm, npc, ir;
  } rec_t;

  rec_t        q[$];
  logic [31:0] mr [32];
  logic        m_vld, m_hlt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] sh);
    return {op, rd, rs1, rs2, sh, 6'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Reference read: R0 is zero, a same-cycle writeback is visible to the reader.
  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return mr[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mr[i] = 32'd0;
    m_vld = 1'b0;
    m_hlt = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    in_valid = 0; npc_in = 0; ir_in = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    ex_ld_vld = 0; ex_ld_rd = 0; flush = 0; out_ready = 1;
  endtask

  task automatic cmp_rec(input rec_t e);
    check("a_o",   a_o,   e.a);
    check("b_o",   b_o,   e.b);
    check("d_o",   d_o,   e.d);
    check("imm_o", imm_o, e.imm);
    check("npc_o", npc_o, e.npc);
    check("ir_o",  ir_o,  e.ir);
  endtask

  // One clock: pre-edge checks and scoreboard traffic on the falling edge,
  // model state update at the rising edge, post-edge state checks 1 time unit later.
  task automatic step();
    rec_t        e;
    logic        haz, adv, exp_rdy, acc;
    logic [4:0]  f_rd, f_rs1, f_rs2, f_sh;
    @(negedge clk);
    f_rd  = ir_in[25:21];
    f_rs1 = ir_in[20:16];
    f_rs2 = ir_in[15:11];
    f_sh  = ir_in[10:6];
    haz = in_valid && ex_ld_vld && ex_ld_rd != 0 &&
          (ex_ld_rd == f_rs1 || ex_ld_rd == f_rs2 || ex_ld_rd == f_rd);
    adv = !m_vld || out_ready;
    exp_rdy = adv && !haz && !m_hlt && !flush;
    check("in_ready", in_ready, exp_rdy);
    if (m_vld && q.size() > 0) begin
      if (out_ready) begin
        e = q.pop_front();
        cmp_rec(e);
      end else if (flush) begin
        void'(q.pop_front());
      end else begin
        check("hold_a",  a_o,  q[0].a);
        check("hold_ir", ir_o, q[0].ir);
      end
    end
    acc = in_valid && exp_rdy;
    if (acc) begin
      e.a   = mread(f_rs1);
      e.b   = mread(f_rs2) << f_sh;
      e.d   = mread(f_rd);
      e.imm = {{16{ir_in[15]}}, ir_in[15:0]};
      e.npc = npc_in;
      e.ir  = ir_in;
      q.push_back(e);
    end
    @(posedge clk);
    if (wb_en && wb_rd != 0) mr[wb_rd] = wb_data;
    if (flush) begin
      m_vld = 1'b0;
      m_hlt = 1'b0;
    end else if (acc) begin
      m_vld = 1'b1;
      if (ir_in[31:26] == 6'h3F) m_hlt = 1'b1;
    end else if (adv) begin
      m_vld = 1'b0;
    end
    #1;
    check("out_valid", out_valid, m_vld);
    check("hlt", hlt, m_hlt);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_hlt",       hlt,       1'b0);
    check("rst_a_o",       a_o,       32'd0);
    check("rst_ir_o",      ir_o,      32'd0);
    check("rst_npc_o",     npc_o,     32'd0);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_b_o",       b_o,       32'd0);
    check("rst_imm_o",     imm_o,     32'd0);
    check("rst_hlt",       hlt,       1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // same-cycle writeback bypass into rs1
    wb_en = 1; wb_rd = 5; wb_data = 32'h1234;
    in_valid = 1; npc_in = 32'h100; ir_in = mk(6'h01, 5'd0, 5'd5, 5'd0, 5'd0);
    step();
    // writes to R0 are ignored, R0 reads zero
    wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    npc_in = 32'h104; ir_in = mk(6'h01, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    wb_en = 0;
    npc_in = 32'h108; ir_in = mk(6'h01, 5'd0, 5'd0, 5'd5, 5'd0);
    step();
    // shifted rs2 and sign-extended immediate
    wb_en = 1; wb_rd = 3; wb_data = 32'h1; in_valid = 0;
    step();
    wb_en = 0; in_valid = 1;
    npc_in = 32'h10C; ir_in = mk(6'h02, 5'd5, 5'd0, 5'd3, 5'd4);
    step();
    npc_in = 32'h110; ir_in = mk_i(6'h03, 5'd3, 5'd5, 16'h8000);
    step();
    in_valid = 0;
    step();

    // load-use stall then release
    ex_ld_vld = 1; ex_ld_rd = 7; wb_en = 1; wb_rd = 7; wb_data = 32'h77;
    in_valid = 1; npc_in = 32'h200; ir_in = mk(6'h04, 5'd1, 5'd7, 5'd0, 5'd0);
    step();
    wb_en = 0; ex_ld_vld = 0;
    step();
    in_valid = 0;
    step();

    // back-pressure: held payload for 3 cycles, then flush kills it
    in_valid = 1; out_ready = 0; npc_in = 32'h300; ir_in = mk(6'h05, 5'd3, 5'd5, 5'd7, 5'd1);
    step();
    npc_in = 32'h304; ir_in = mk(6'h06, 5'd0, 5'd3, 5'd0, 5'd0);
    wb_en = 1; wb_rd = 5; wb_data = 32'hDEAD;
    repeat (3) step();
    wb_en = 0; in_valid = 0; flush = 1;
    step();
    flush = 0; out_ready = 1;
    step();

    // halt: passes through, then blocks input; writeback continues; flush clears it
    in_valid = 1; npc_in = 32'h400; ir_in = mk(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    npc_in = 32'h404; ir_in = mk(6'h01, 5'd0, 5'd9, 5'd0, 5'd0);
    wb_en = 1; wb_rd = 9; wb_data = 32'hABCD;
    repeat (2) step();
    wb_en = 0; flush = 1;
    step();
    flush = 0;
    step();
    in_valid = 0;
    step();

    // reset pulse in the middle of a stall
    in_valid = 1; out_ready = 0; npc_in = 32'h500; ir_in = mk(6'h01, 5'd1, 5'd5, 5'd9, 5'd0);
    step();
    step();
    pulse_reset();
    out_ready = 1; npc_in = 32'h504; ir_in = mk(6'h01, 5'd9, 5'd5, 5'd3, 5'd2);
    step();
    in_valid = 0;
    step();

    // random traffic
    for (int n = 0; n < 120; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      npc_in    = $urandom;
      ir_in     = $urandom;
      if (ir_in[31:26] == 6'h3F && $urandom_range(0, 3) != 0) ir_in[31:26] = 6'h10;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = $urandom_range(0, 1);
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      ex_ld_vld = ($urandom_range(0, 3) == 0);
      ex_ld_rd  = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
